// File: rtl/axis_pkt_fifo_pkg.sv
// Shared sizing helpers for the AXI4-Stream packet FIFO and its storage RAM.
package axis_pkt_fifo_pkg;

    localparam int BITS_PER_STRB = 8;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int strb_width(input int data_width);
        return data_width / BITS_PER_STRB;
    endfunction

    // Stored beat is {tlast, tstrb, tdata}, tlast at the MSB.
    function automatic int beat_width(input int data_width);
        return data_width + strb_width(data_width) + 1;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable/hold.
module axis_pkt_fifo_sdp_ram #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array itself is not reset so it maps onto block RAM; only the read register is.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI4-Stream FWFT FIFO with registered-read RAM, occupancy count and programmable flags.
// Define AXIS_PKT_FIFO_STORE_FWD_EN to hold each packet back until its tlast beat is stored.
module axis_pkt_fifo
    import axis_pkt_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH        = 128,
    parameter  int DEPTH             = 1024,
    parameter  int PROG_FULL_THRESH  = 254,
    parameter  int PROG_EMPTY_THRESH = 10,
    parameter  int CNT_W             = cnt_width(DEPTH),
    localparam int STRB_W            = strb_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [STRB_W-1:0]     s_axis_tstrb,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [STRB_W-1:0]     m_axis_tstrb,
    output logic                  m_axis_tlast,
    output logic [CNT_W-1:0]      data_count,
    output logic                  prog_full,
    output logic                  prog_empty
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int BEAT_W = beat_width(DATA_WIDTH);

    typedef struct packed {
        logic                  tlast;
        logic [STRB_W-1:0]     tstrb;
        logic [DATA_WIDTH-1:0] tdata;
    } beat_t;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] avail_cnt;
    logic [CNT_W-1:0] count_nxt;
    logic             wr_commit;
    logic             push, pop, rd_issue, rd_gate;
    beat_t            wr_beat, rd_beat;

    assign push     = s_axis_tvalid && s_axis_tready;
    assign pop      = m_axis_tvalid && m_axis_tready;
    assign rd_issue = (avail_cnt != '0) && (!m_axis_tvalid || m_axis_tready) && rd_gate;

    assign wr_beat = '{tlast: s_axis_tlast, tstrb: s_axis_tstrb, tdata: s_axis_tdata};
    assign {m_axis_tlast, m_axis_tstrb, m_axis_tdata} = rd_beat;

    always_comb begin
        // NOTE: assigning the default first keeps this purely combinational (no latch).
        count_nxt = data_count;
        if (push && !pop)      count_nxt = data_count + CNT_W'(1);
        else if (pop && !push) count_nxt = data_count - CNT_W'(1);
    end

    // A written entry becomes readable one edge after its write (wr_commit), so a read
    // never targets the address being written and first-beat latency is two edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            avail_cnt     <= '0;
            wr_commit     <= 1'b0;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b0;
            data_count    <= '0;
            prog_full     <= 1'b0;
            prog_empty    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            wr_commit <= push;
            if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_issue) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_commit, rd_issue})
                2'b10:   avail_cnt <= avail_cnt + CNT_W'(1);
                2'b01:   avail_cnt <= avail_cnt - CNT_W'(1);
                default: avail_cnt <= avail_cnt;
            endcase
            if (rd_issue) m_axis_tvalid <= 1'b1;
            else if (pop) m_axis_tvalid <= 1'b0;
            data_count    <= count_nxt;
            s_axis_tready <= int'(count_nxt) < DEPTH;
            prog_full     <= int'(count_nxt) >= PROG_FULL_THRESH;
            prog_empty    <= int'(count_nxt) <= PROG_EMPTY_THRESH;
        end
    end

    axis_pkt_fifo_sdp_ram #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_beat),
        .re    (rd_issue),
        .raddr (rd_ptr),
        .rdata (rd_beat)
    );

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
    logic             last_mem [DEPTH];
    logic [CNT_W-1:0] pkt_cnt;
    logic             commit_last;
    logic             esc;
    logic             rd_last;

    assign rd_last = last_mem[rd_ptr];
    assign rd_gate = (pkt_cnt != '0) || esc;

    always_ff @(posedge clk) begin
        if (push) last_mem[wr_ptr] <= s_axis_tlast;
    end

    // Escape releases the gate when the FIFO is full of a packet with no tlast yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt     <= '0;
            commit_last <= 1'b0;
            esc         <= 1'b0;
        end else begin
            commit_last <= push && s_axis_tlast;
            case ({wr_commit && commit_last, rd_issue && rd_last})
                2'b10:   pkt_cnt <= pkt_cnt + CNT_W'(1);
                2'b01:   pkt_cnt <= pkt_cnt - CNT_W'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
            if (rd_issue && rd_last)
                esc <= 1'b0;
            else if ((int'(data_count) == DEPTH) && (pkt_cnt == '0))
                esc <= 1'b1;
        end
    end
`else
    assign rd_gate = 1'b1;
`endif

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed self-checking bench for axis_pkt_fifo (DEPTH=16, DATA_WIDTH=32).
module tb_axis_pkt_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int PF    = 14;
    localparam int PE    = 2;
    localparam int SW    = DW / 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_tvalid, s_tready, s_tlast;
    logic [DW-1:0] s_tdata;
    logic [SW-1:0] s_tstrb;
    logic          m_tvalid, m_tready, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [SW-1:0] m_tstrb;
    logic [CW-1:0] data_count;
    logic          prog_full, prog_empty;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axis_pkt_fifo #(
        .DATA_WIDTH        (DW),
        .DEPTH             (DEPTH),
        .PROG_FULL_THRESH  (PF),
        .PROG_EMPTY_THRESH (PE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tlast  (m_tlast),
        .data_count    (data_count),
        .prog_full     (prog_full),
        .prog_empty    (prog_empty)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tready"}, s_tready, 1'b0);
        check({tag, "_mvalid"}, m_tvalid, 1'b0);
        check({tag, "_mdata"}, {m_tlast, m_tstrb, m_tdata}, '0);
        check({tag, "_count"}, data_count, 0);
        check({tag, "_pfull"}, prog_full, 1'b0);
        check({tag, "_pempty"}, prog_empty, 1'b1);
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0; m_tready = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic drain();
        int cyc = 0;
        m_tready = 1'b1;
        while ((data_count != 0) && (cyc < 100)) begin
            tick();
            cyc++;
        end
        m_tready = 1'b0;
        check("drain_count", data_count, 0);
    endtask

    // Streams n beats through a queue scoreboard; optional random valid/ready.
    task automatic run_stream(input int n, input int last_every, input bit rnd, input logic [31:0] base);
        logic [SW+DW:0] q[$];
        logic [SW+DW:0] exp_b;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        while ((got < n) && (cyc < 3000)) begin
            s_tvalid = (sent < n) && (!rnd || ($urandom_range(3) != 0));
            s_tdata  = base + sent;
            s_tstrb  = SW'(sent * 3);
            s_tlast  = (last_every != 0) && ((sent % last_every) == (last_every - 1));
            m_tready = !rnd || ($urandom_range(1) == 1);
            if (m_tvalid && m_tready) begin
                if (q.size() == 0) begin
                    check("stream_underflow", m_tvalid, 1'b0);
                end else begin
                    exp_b = q.pop_front();
                    check("stream_beat", {m_tlast, m_tstrb, m_tdata}, exp_b);
                end
                got++;
            end
            if (s_tvalid && s_tready) begin
                q.push_back({s_tlast, s_tstrb, s_tdata});
                sent++;
            end
            tick();
            cyc++;
            check("stream_count", data_count, q.size());
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        check("stream_done", got, n);
    endtask

    initial begin
        int acc;
        bit took;
        logic [SW-1:0] exp_strb;

        s_tvalid = 1'b0; s_tdata = '0; s_tstrb = '0; s_tlast = 1'b0; m_tready = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;

        // Reset and idle
        tick(); tick();
        check_reset_vals("rst");
        rst = 1'b0;
        check("rst_rel_tready_pre", s_tready, 1'b0);
        tick();
        check("rst_rel_tready", s_tready, 1'b1);
        check("rst_rel_mvalid", m_tvalid, 1'b0);
        check("rst_rel_count", data_count, 0);
        check("rst_rel_pempty", prog_empty, 1'b1);

`ifndef AXIS_PKT_FIFO_STORE_FWD_EN
        // Latency and ordering: 16 back-to-back beats, sink always ready
        m_tready = 1'b1;
        s_tvalid = 1'b1; s_tdata = 32'h1; s_tstrb = SW'(1); s_tlast = 1'b0;
        for (int e = 0; e < 20; e++) begin
            tick();
            check("lat_mvalid", m_tvalid, (e >= 2) && (e <= 17));
            if ((e >= 2) && (e <= 17)) begin
                exp_strb = SW'(e - 1);
                check("lat_data", m_tdata, e - 1);
                check("lat_strb", m_tstrb, exp_strb);
                check("lat_last", m_tlast, e == 17);
            end
            if (e + 1 < 16) begin
                s_tdata = e + 2; s_tstrb = SW'(e + 2); s_tlast = (e + 2 == 16);
            end else begin
                s_tvalid = 1'b0; s_tlast = 1'b0;
            end
        end
        check("lat_end_count", data_count, 0);

        // Full and backpressure
        m_tready = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            s_tvalid = 1'b1; s_tdata = 32'h100 + acc; s_tstrb = '1; s_tlast = 1'b0;
            took = s_tready;
            tick();
            if (took) acc++;
        end
        s_tvalid = 1'b0;
        check("full_accepted", acc, 16);
        check("full_count", data_count, 16);
        check("full_tready", s_tready, 1'b0);
        check("full_pfull", prog_full, 1'b1);
        check("full_mdata", m_tdata, 32'h100);
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        check("pop1_count", data_count, 15);
        check("pop1_tready", s_tready, 1'b1);
        check("pop1_mdata", m_tdata, 32'h101);
        check("pop1_pfull", prog_full, 1'b1);
        drain();

        // Simultaneous push and pop at occupancy 8
        for (int k = 0; k < 8; k++) begin
            s_tvalid = 1'b1; s_tdata = 32'h200 + k; s_tstrb = SW'(k); s_tlast = 1'b0;
            tick();
        end
        s_tvalid = 1'b0;
        tick();
        check("pp_fill_count", data_count, 8);
        m_tready = 1'b1; s_tvalid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            s_tdata = 32'h208 + c; s_tstrb = SW'(8 + c);
            exp_strb = SW'(c);
            check("pp_mvalid", m_tvalid, 1'b1);
            check("pp_data", m_tdata, 32'h200 + c);
            check("pp_strb", m_tstrb, exp_strb);
            tick();
            check("pp_count", data_count, 8);
        end
        s_tvalid = 1'b0;
        drain();

        // Random traffic wrapping the pointers several times
        run_stream(100, 7, 1'b1, 32'h1000);
`else
        // Store-and-forward: nothing leaves before tlast is stored
        m_tready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            s_tvalid = 1'b1; s_tdata = k; s_tstrb = SW'(k); s_tlast = 1'b0;
            tick();
            check("sf_hold_push", m_tvalid, 1'b0);
        end
        s_tvalid = 1'b0;
        for (int g = 0; g < 10; g++) begin
            tick();
            check("sf_hold_gap", m_tvalid, 1'b0);
        end
        s_tvalid = 1'b1; s_tdata = 5; s_tstrb = SW'(5); s_tlast = 1'b1;
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        check("sf_last_e0", m_tvalid, 1'b0);
        tick();
        check("sf_last_e1", m_tvalid, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("sf_out_valid", m_tvalid, 1'b1);
            check("sf_out_data", m_tdata, k);
            check("sf_out_last", m_tlast, k == 5);
        end
        tick();
        check("sf_out_idle", m_tvalid, 1'b0);

        // Oversize packet without tlast drains through the escape
        run_stream(20, 0, 1'b0, 32'h600);
        do_reset();
`endif

        // Reset asserted mid-packet
        m_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_tvalid = 1'b1; s_tdata = 32'h700 + k; s_tstrb = '1; s_tlast = 1'b0;
            tick();
        end
        s_tvalid = 1'b0;
        check("mid_pre_count", data_count, 3);
        rst = 1'b1;
        #1;
        check_reset_vals("mid_rst");
        tick(); tick();
        rst = 1'b0;
        tick();
        check("mid_rel_tready", s_tready, 1'b1);
        run_stream(10, 5, 1'b0, 32'h500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
- Parametrised synchronous AXI4-Stream FIFO that replaces the xpm_fifo_sync plus external tlast-register glue around the systolic array's read and write paths.
- Carries tdata, tstrb and tlast together in storage, so tlast stays aligned with its beat.
- Uses native ready/valid with first-word fall-through, and provides programmable full/empty flags and an occupancy count.
- Optional packet (store-and-forward) mode.

Parameters:
- DATA_WIDTH, 128: tdata width in bits; must be a multiple of 8. tstrb is DATA_WIDTH/8 bits.
- DEPTH, 1024: total capacity in beats; power of two, at least 4.
- PROG_FULL_THRESH, 254: prog_full asserts when data_count >= this value.
- PROG_EMPTY_THRESH, 10: prog_empty asserts when data_count <= this value.
- CNT_W, $clog2(DEPTH)+1: width of data_count. Derived; do not override.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: asynchronous, active-high reset.
- s_axis_tvalid, input, 1: slave beat valid.
- s_axis_tready, output, 1: slave ready.
- s_axis_tdata, input, DATA_WIDTH: slave data.
- s_axis_tstrb, input, DATA_WIDTH/8: slave strobes, stored unmodified.
- s_axis_tlast, input, 1: slave end of packet.
- m_axis_tvalid, output, 1: master beat valid.
- m_axis_tready, input, 1: master ready.
- m_axis_tdata, output, DATA_WIDTH: master data.
- m_axis_tstrb, output, DATA_WIDTH/8: master strobes.
- m_axis_tlast, output, 1: master end of packet.
- data_count, output, CNT_W: beats accepted but not yet emitted, including the output register.
- prog_full, output, 1: data_count >= PROG_FULL_THRESH.
- prog_empty, output, 1: data_count <= PROG_EMPTY_THRESH.

Behaviour:
- Reset values while rst is high: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tstrb/tlast=0, data_count=0, prog_full=0, prog_empty=1. Pointers clear to 0.
- After reset: s_axis_tready rises on the first clk edge after rst deasserts.
- Reset asserted mid-packet: all contents are discarded immediately, asynchronously. There is no partial flush.
- Push: occurs on s_axis_tvalid && s_axis_tready. s_axis_tready = (data_count < DEPTH), registered from next-state count.
- Pop: occurs on m_axis_tvalid && m_axis_tready.
- Storage: a RAM with registered read. The RAM output register is the master output register.
- Read issue: when the RAM holds at least one entry and (!m_axis_tvalid || m_axis_tready).
- Latency: a beat pushed at edge N into an empty FIFO shows m_axis_tvalid=1 from edge N+2.
- Throughput: 1 beat/cycle sustained in both directions.
- Output stability: m_axis_tdata/tstrb/tlast hold stable while tvalid && !tready. Once asserted, tvalid is never dropped without a pop.
- Push and pop in the same cycle: data_count unchanged. At data_count==DEPTH, a pop frees space and tready returns on the next edge; there is no same-cycle pass-through.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. RAM occupancy is tracked separately. The output register holds 1 beat, so the RAM holds at most DEPTH-1.
- Flags: prog_full and prog_empty are registered from next-state data_count, so they are coincident with data_count.
- Error handling: none. Overflow and underflow cannot occur by construction.

Optional Feature:
- Macro: AXIS_PKT_FIFO_STORE_FWD_EN.
- When defined:
  - A packet counter increments on a pushed beat with tlast=1.
  - It decrements when a read is issued for an entry with tlast=1. The tlast bits are also held in a side array with asynchronous read at rd_ptr.
  - Read issue additionally requires packet count > 0, so m_axis never starts a packet before its tlast is stored.
  - Oversize escape: if data_count==DEPTH and packet count==0, gating is released until the next tlast read issues, which prevents deadlock.
- When not defined: plain FWFT behaviour as above. The packet counter and side array are not synthesised.

Decomposition:
- Package axis_pkt_fifo_pkg holds:
  - a function for the count width;
  - a parametrised-width beat struct typedef {tdata, tstrb, tlast}, packed as tlast at MSB, then tstrb, then tdata;
  - localparam helpers for the strobe width.
- Sub-module axis_pkt_fifo_sdp_ram: simple dual-port RAM with 1 write port, 1 registered read port, read-enable and hold, sized DEPTH x (DATA_WIDTH+DATA_WIDTH/8+1).

Test Plan:
- Reset/idle (DEPTH=16): hold rst for 2 cycles, then release. Expect tready=0 during reset and 1 on the first edge after release; m_axis_tvalid=0, data_count=0, prog_empty=1.
- Latency/order: push 0x1..0x10 back-to-back with m_axis_tready=1. Expect first m_axis_tvalid 2 edges after the first push, data 0x1..0x10 in order with no bubbles, and tlast only on 0x10.
- Full/backpressure: m_axis_tready=0, push 20 beats. Expect 16 accepted, tready=0 at data_count=16, prog_full=1 (THRESH=14). Then one pop gives tready=1 on the next edge and data_count=15.
- Simultaneous push/pop at data_count=8 for 50 cycles: data_count stays 8, output matches the input stream delayed by 8 beats, and tstrb values pass through unchanged.
- Wrap and reset mid-stream: run 100 beats with random ready/valid so pointers wrap 6 times, and check against a scoreboard. Assert rst mid-packet: all outputs return to reset values in the same cycle and subsequent traffic is clean.
- With AXIS_PKT_FIFO_STORE_FWD_EN:
  - Push a 5-beat packet with a 10-cycle gap before tlast. Expect m_axis_tvalid=0 until 2 edges after the tlast push.
  - Push an oversize packet of 20 beats with no tlast. Expect the escape to drain it without deadlock.
